// File: rtl/id_hazard_ctrl.sv
// Decode-stage scoreboard: per-register pending counters gate issue into the ID/EX register.
// A flush blocks issue for FLUSH_CYCLES cycles and retires the killed ID/EX writer.
module id_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic        ex_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic        id_stall,
  output logic        id_ex_valid,
  output logic [4:0]  id_ex_rd,
  output logic [31:0] busy_mask
);

  typedef enum logic {RUN, DRAIN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [3:0]       DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic             id_ex_valid_q, id_ex_valid_d;
  logic [4:0]       id_ex_rd_q, id_ex_rd_d;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2, eff_rd;
  logic       rs1_used, rs2_used, hazard, issue;
  logic       unused_funct;

  assign opcode       = id_instr[6:0];
  assign rd           = id_instr[11:7];
  assign rs1          = id_instr[19:15];
  assign rs2          = id_instr[24:20];
  assign unused_funct = ^{id_instr[31:25], id_instr[14:12]};

  assign rs1_used = !(opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
  assign rs2_used = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
  assign eff_rd   = (opcode inside {7'b0100011, 7'b1100011}) ? 5'd0 : rd;

  // Hazard looks only at registered counters: a writeback frees its register one cycle later.
  assign hazard = (rs1_used && rs1 != 5'd0 && cnt_q[rs1] != '0)
               || (rs2_used && rs2 != 5'd0 && cnt_q[rs2] != '0)
               || (eff_rd != 5'd0 && cnt_q[eff_rd] == CNT_MAX);

  assign issue    = !reset && state_q == RUN && id_valid && ex_ready && !hazard && !flush;
  assign id_stall = id_valid && !issue;

  assign id_ex_valid = id_ex_valid_q;
  assign id_ex_rd    = id_ex_rd_q;

  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cur,
                                                input logic inc, input logic dec_a,
                                                input logic dec_b);
    logic [CNT_W+1:0] up, dn, diff;
    up   = {2'b00, cur} + {{(CNT_W+1){1'b0}}, inc};
    dn   = {{(CNT_W+1){1'b0}}, dec_a} + {{(CNT_W+1){1'b0}}, dec_b};
    diff = up - dn;
    return (up > dn) ? diff[CNT_W-1:0] : '0;
  endfunction

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      cnt_d[i]     = '0;
      busy_mask[i] = cnt_q[i] != '0;
    end
    for (int i = 1; i < 32; i++) begin
      cnt_d[i] = next_cnt(cnt_q[i],
                          issue && eff_rd == 5'(i),
                          wb_valid && wb_rd == 5'(i),
                          flush && id_ex_valid_q && id_ex_rd_q == 5'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (flush) begin
          drain_d = DRAIN_LOAD;
        end else if (drain_q == 4'd0) begin
          state_d = RUN;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    id_ex_valid_d = id_ex_valid_q;
    id_ex_rd_d    = id_ex_rd_q;
    if (flush) begin
      id_ex_valid_d = 1'b0;
      id_ex_rd_d    = 5'd0;
    end else if (ex_ready) begin
      id_ex_valid_d = issue;
      id_ex_rd_d    = issue ? eff_rd : 5'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      drain_q       <= 4'd0;
      id_ex_valid_q <= 1'b0;
      id_ex_rd_q    <= 5'd0;
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      id_ex_valid_q <= id_ex_valid_d;
      id_ex_rd_q    <= id_ex_rd_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: hand-computed expectations per cycle.
module tb_id_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        ex_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        id_stall;
  logic        id_ex_valid;
  logic [4:0]  id_ex_rd;
  logic [31:0] busy_mask;

  int n_chk;
  int n_err;

  id_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .ex_ready   (ex_ready),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .flush      (flush),
    .id_stall   (id_stall),
    .id_ex_valid(id_ex_valid),
    .id_ex_rd   (id_ex_rd),
    .busy_mask  (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd1, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] add_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] src, input logic [4:0] base);
    return {7'd0, src, base, 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic logic [31:0] lui(input logic [4:0] rd);
    return {20'h00001, rd, 7'b0110111};
  endfunction

  // Apply inputs just after an edge, then let combinational outputs settle.
  task automatic drv(input logic v, input logic [31:0] ins, input logic rdy,
                     input logic wbv, input logic [4:0] wbr, input logic fl);
    id_valid = v;
    id_instr = ins;
    ex_ready = rdy;
    wb_valid = wbv;
    wb_rd    = wbr;
    flush    = fl;
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    drv(1'b1, addi(5'd1, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
    check("rst_busy", busy_mask, 32'h0);
    check("rst_idex_v", 32'(id_ex_valid), 32'd0);
    check("rst_idex_rd", 32'(id_ex_rd), 32'd0);
    check("rst_stall_v1", 32'(id_stall), 32'd1);
    drv(1'b0, addi(5'd1, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
    check("rst_stall_v0", 32'(id_stall), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // RAW: ADDI x5 then ADD x6,x5,x1
    drv(1'b1, addi(5'd5, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
    check("raw_addi_issue", 32'(id_stall), 32'd0);
    tick();
    drv(1'b1, add_r(5'd6, 5'd5, 5'd1), 1'b1, 1'b0, 5'd0, 1'b0);
    check("raw_idex_v", 32'(id_ex_valid), 32'd1);
    check("raw_idex_rd", 32'(id_ex_rd), 32'd5);
    check("raw_busy5", busy_mask, 32'h0000_0020);
    check("raw_stall", 32'(id_stall), 32'd1);
    tick();
    drv(1'b1, add_r(5'd6, 5'd5, 5'd1), 1'b1, 1'b1, 5'd5, 1'b0);
    check("raw_no_bypass", 32'(id_stall), 32'd1);
    check("raw_bubble", 32'(id_ex_valid), 32'd0);
    tick();
    drv(1'b1, add_r(5'd6, 5'd5, 5'd1), 1'b1, 1'b0, 5'd0, 1'b0);
    check("raw_busy_clr", busy_mask, 32'h0);
    check("raw_go", 32'(id_stall), 32'd0);
    tick();
    drv(1'b0, 32'h0, 1'b1, 1'b1, 5'd6, 1'b0);
    check("raw_busy6", busy_mask, 32'h0000_0040);
    check("raw_idex_rd6", 32'(id_ex_rd), 32'd6);
    tick();

    // Store: SW x5,0(x2)
    drv(1'b1, addi(5'd5, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
    check("st_busy_empty", busy_mask, 32'h0);
    tick();
    drv(1'b1, sw(5'd5, 5'd2), 1'b1, 1'b0, 5'd0, 1'b0);
    check("st_stall", 32'(id_stall), 32'd1);
    tick();
    drv(1'b1, sw(5'd5, 5'd2), 1'b1, 1'b1, 5'd5, 1'b0);
    check("st_stall_wb", 32'(id_stall), 32'd1);
    tick();
    drv(1'b1, sw(5'd5, 5'd2), 1'b1, 1'b0, 5'd0, 1'b0);
    check("st_go", 32'(id_stall), 32'd0);
    tick();
    drv(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    check("st_idex_v", 32'(id_ex_valid), 32'd1);
    check("st_idex_rd", 32'(id_ex_rd), 32'd0);
    check("st_busy", busy_mask, 32'h0);
    tick();

    // Counter saturation on x7
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, addi(5'd7, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
      check("sat_issue", 32'(id_stall), 32'd0);
      tick();
    end
    drv(1'b1, addi(5'd7, 5'd0), 1'b1, 1'b1, 5'd7, 1'b0);
    check("sat_busy7", busy_mask, 32'h0000_0080);
    check("sat_stall", 32'(id_stall), 32'd1);
    tick();
    drv(1'b1, addi(5'd7, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
    check("sat_go", 32'(id_stall), 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drv(1'b0, 32'h0, 1'b1, 1'b1, 5'd7, 1'b0);
      tick();
    end
    drv(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    check("sat_drained", busy_mask, 32'h0);

    // Flush kills ID/EX x9 writer and blocks issue for two cycles
    drv(1'b1, addi(5'd9, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
    check("fl_x9_issue", 32'(id_stall), 32'd0);
    tick();
    drv(1'b1, addi(5'd10, 5'd0), 1'b1, 1'b0, 5'd0, 1'b1);
    check("fl_busy9", busy_mask, 32'h0000_0200);
    check("fl_stall_now", 32'(id_stall), 32'd1);
    tick();
    drv(1'b1, addi(5'd10, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
    check("fl_idex_v", 32'(id_ex_valid), 32'd0);
    check("fl_cnt9_zero", busy_mask, 32'h0);
    check("fl_drain1", 32'(id_stall), 32'd1);
    tick();
    drv(1'b1, addi(5'd10, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
    check("fl_drain2", 32'(id_stall), 32'd1);
    tick();
    drv(1'b1, addi(5'd10, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
    check("fl_run", 32'(id_stall), 32'd0);
    tick();
    drv(1'b0, 32'h0, 1'b1, 1'b1, 5'd10, 1'b0);
    tick();

    // Issue and writeback to the same register cancel; ex_ready low holds ID/EX
    drv(1'b1, addi(5'd3, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b1, lui(5'd3), 1'b1, 1'b1, 5'd3, 1'b0);
    check("lui_issue", 32'(id_stall), 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, addi(5'd4, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0);
      check("hold_busy3", busy_mask, 32'h0000_0008);
      check("hold_stall", 32'(id_stall), 32'd1);
      check("hold_idex_v", 32'(id_ex_valid), 32'd1);
      check("hold_idex_rd", 32'(id_ex_rd), 32'd3);
      tick();
    end

    // Reset in the middle of DRAIN with x5 and x9 pending
    drv(1'b0, 32'h0, 1'b1, 1'b1, 5'd3, 1'b0);
    tick();
    drv(1'b1, addi(5'd5, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b1, addi(5'd9, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1);
    tick();
    drv(1'b1, addi(5'd11, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
    check("mr_busy", busy_mask, 32'h0000_0220);
    check("mr_drain_stall", 32'(id_stall), 32'd1);
    reset = 1'b1;
    #1;
    check("mr_busy_clr", busy_mask, 32'h0);
    check("mr_idex_v", 32'(id_ex_valid), 32'd0);
    check("mr_stall_rst", 32'(id_stall), 32'd1);
    tick();
    reset = 1'b0;
    drv(1'b1, addi(5'd5, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0);
    check("mr_first_issue", 32'(id_stall), 32'd0);
    tick();
    drv(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    check("mr_idex_v1", 32'(id_ex_valid), 32'd1);
    check("mr_idex_rd5", 32'(id_ex_rd), 32'd5);
    check("mr_busy5", busy_mask, 32'h0000_0020);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
